// File: rtl/outcond_pkg.sv
// Shared state encodings for the output conditioner.
// Bit 1 of every state is the driven level, bit 0 marks a running dwell.
package outcond_pkg;

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'b00,
        LOW_HOLD  = 2'b01,
        HIGH_IDLE = 2'b10,
        HIGH_HOLD = 2'b11
    } state_t;

    function automatic state_t make_state(input logic level, input logic hold);
        return state_t'({level, hold});
    endfunction

endpackage

// File: rtl/output_conditioner_dwell_timer.sv
// Dwell counter: load restarts at 0, enable advances it, expire flags the last
// dwell cycle. The count parks on the last value instead of running on.
module dwell_timer #(
    parameter int counterwidth = 3,
    parameter int waittime     = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    if ((2 ** counterwidth) <= waittime) begin : g_width_check
        $error("dwell_timer: counterwidth too small for waittime");
    end

    localparam logic [counterwidth-1:0] LAST =
        (waittime == 0) ? '0 : counterwidth'(waittime - 1);

    logic [counterwidth-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + counterwidth'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/output_conditioner.sv
// Rebuilds a clean level from set/clear request pulses, holding each level for
// at least waittime cycles and deferring one opposite request during the hold.
module output_conditioner
    import outcond_pkg::*;
#(
    parameter int counterwidth = 3,
    parameter int waittime     = 3
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   setpulse,
    input  logic   clearpulse,
    output logic   drivensignal,
    output logic   positiveedge,
    output logic   negativeedge,
    output logic   busy,
    output logic   pending,
    output state_t fsm_state
);

    localparam logic HOLD_EN = (waittime != 0);

    state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   pos_q, pos_d, neg_q, neg_d;
    logic   load, expire;
    logic   level, hold, set_req, clr_req, flip_req, same_req, pend_next;

    dwell_timer #(
        .counterwidth(counterwidth),
        .waittime    (waittime)
    ) u_dwell (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .enable (hold),
        .expire (expire)
    );

    // The pending direction is always the opposite of the current level,
    // because a same-level request cancels it; no separate bit is stored.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pos_d     = 1'b0;
        neg_d     = 1'b0;
        load      = 1'b0;
        level     = state_q[1];
        hold      = state_q[0];
        set_req   = setpulse & ~clearpulse;
        clr_req   = clearpulse & ~setpulse;
        flip_req  = level ? clr_req : set_req;
        same_req  = level ? set_req : clr_req;
        pend_next = pending_q;

        if (!hold) begin
            if (flip_req) begin
                state_d = make_state(~level, HOLD_EN);
                load    = 1'b1;
                pos_d   = ~level;
                neg_d   = level;
            end
        end else begin
            if (flip_req) begin
                pend_next = 1'b1;
            end else if (same_req) begin
                pend_next = 1'b0;
            end
            if (expire) begin
                pending_d = 1'b0;
                if (pend_next) begin
                    state_d = make_state(~level, 1'b1);
                    load    = 1'b1;
                    pos_d   = ~level;
                    neg_d   = level;
                end else begin
                    state_d = make_state(level, 1'b0);
                end
            end else begin
                pending_d = pend_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= LOW_IDLE;
            pending_q <= 1'b0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
        end
    end

    assign drivensignal = state_q[1];
    assign busy         = state_q[0];
    assign pending      = pending_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;
    assign fsm_state    = state_q;

endmodule
